// File: rtl/arith_shift_pkg.sv
// arith_shift_pkg: state encoding and default sizes for the arithmetic shift sequencer
package arith_shift_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_AMT_W = 3;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
endpackage

// File: rtl/arith_shift1_right.sv
// arith_shift1_right: combinational 1-bit arithmetic right shift with sign replication
module arith_shift1_right #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] x
);
  assign x = {a[WIDTH-1], a[WIDTH-1:1]};
endmodule

// File: rtl/arith_shift_seq_ctrl.sv
// arith_shift_seq_ctrl: one-bit-per-cycle arithmetic right shift sequencer; ARITH_SHIFT_EARLY_EXIT_EN enables early termination
module arith_shift_seq_ctrl
  import arith_shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AMT_W = DEF_AMT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [AMT_W-1:0] amt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] x
);
  logic [1:0] state;
  logic [AMT_W-1:0] cnt;
  logic [WIDTH-1:0] sx;
  logic accept, early_a, early_s;
  arith_shift1_right #(.WIDTH(WIDTH)) u_sh (.a(x), .x(sx));
  assign accept = start && (state == ST_IDLE || state == ST_DONE);
`ifdef ARITH_SHIFT_EARLY_EXIT_EN
  assign early_a = &a || ~|a;
  assign early_s = &sx || ~|sx;
`else
  assign early_a = 1'b0;
  assign early_s = 1'b0;
`endif
  assign busy = state == ST_SHIFT;
  assign done = state == ST_DONE;
  // FSM, down-counter and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      x     <= '0;
    end else if (accept) begin
      x     <= a;
      cnt   <= amt;
      state <= (amt == '0 || early_a) ? ST_DONE : ST_SHIFT;
    end else if (state == ST_SHIFT) begin
      x     <= sx;
      cnt   <= cnt - AMT_W'(1);
      state <= (cnt == AMT_W'(1) || early_s) ? ST_DONE : ST_SHIFT;
    end else if (state == ST_DONE) begin
      state <= ST_IDLE;
    end
  end
endmodule

// File: tb/tb_arith_shift_seq_ctrl.sv
// tb_arith_shift_seq_ctrl: directed self-checking bench for arith_shift_seq_ctrl
module tb_arith_shift_seq_ctrl;
  logic clk = 0, rst = 1, start = 0;
  logic [3:0] a = '0;
  logic [2:0] amt = '0;
  logic busy, done;
  logic [3:0] x;
  int errs = 0, checks = 0;

  arith_shift_seq_ctrl dut (.clk(clk), .rst(rst), .start(start), .a(a), .amt(amt),
                            .busy(busy), .done(done), .x(x));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] av, input logic [2:0] kv);
    @(negedge clk);
    start = 1; a = av; amt = kv;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input string tag, input logic [3:0] exp_x, input int exp_lat, input int lat0);
    int lat = lat0, bc = 0, both = 0;
    while (!done && lat < 40) begin
      if (busy) bc++;
      @(negedge clk);
      lat++;
    end
    if (busy && done) both++;
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_busy_cycles"}, bc, exp_lat - lat0);
    chk({tag, "_busy_done_overlap"}, both, 0);
    chk({tag, "_x"}, x, exp_x);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_x", x, 0);
    rst = 0;
    issue(4'b0110, 3'd1);
    wait_done("pos6_sh1", 4'b0011, 2, 1);
    issue(4'b1011, 3'd1);
    wait_done("neg5_sh1", 4'b1101, 2, 1);
    issue(4'b1000, 3'd3);
    wait_done("neg8_sh3", 4'b1111, 4, 1);
    issue(4'b0101, 3'd0);
    wait_done("amt0", 4'b0101, 1, 1);
    issue(4'b0001, 3'd7);
`ifdef ARITH_SHIFT_EARLY_EXIT_EN
    wait_done("one_sh7", 4'b0000, 2, 1);
`else
    wait_done("one_sh7", 4'b0000, 8, 1);
`endif
    @(negedge clk);
    chk("idle_done_low", done, 0);
    a = 4'b1010;
    @(negedge clk);
    chk("idle_x_held", x, 4'b0000);
    issue(4'b0110, 3'd3);
    chk("ign_busy_c1", busy, 1);
    start = 1; a = 4'b1111; amt = 3'd0;
    @(negedge clk);
    start = 0;
    chk("ign_busy_c2", busy, 1);
    wait_done("ignore_start", 4'b0000, 4, 2);
    start = 1; a = 4'b1011; amt = 3'd2;
    @(negedge clk);
    start = 0;
    wait_done("b2b", 4'b1110, 3, 1);
    issue(4'b1000, 3'd3);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_x", x, 0);
    begin
      int dseen = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (done || busy) dseen++;
      end
      chk("abort_no_done", dseen, 0);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
